// File: rtl/icache_refill_bridge.sv
// Instruction-cache refill bridge: turns icache line misses into one memory read,
// assembles the returned beats into a line and forwards coherence invalidations.
module icache_refill_bridge #(
    parameter int PADDR_SIZE = 40,
    parameter int LINE_BITS  = 128,
    parameter int BEAT_BITS  = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  ifill_req_valid_i,
    input  logic [PADDR_SIZE-1:0] ifill_req_paddr_i,
    output logic                  ifill_req_ready_o,
    output logic                  ifill_resp_valid_o,
    output logic                  ifill_resp_ack_o,
    output logic [LINE_BITS-1:0]  ifill_resp_data_o,
    output logic                  ifill_resp_inv_valid_o,
    output logic [PADDR_SIZE-1:0] ifill_resp_inv_paddr_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PADDR_SIZE-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [BEAT_BITS-1:0]  mem_resp_data_i,
    input  logic                  inv_valid_i,
    input  logic [PADDR_SIZE-1:0] inv_paddr_i,
    output logic                  inv_ready_o
);

    localparam int BEATS      = LINE_BITS / BEAT_BITS;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [PADDR_SIZE-1:0] LINE_MASK = ~(PADDR_SIZE'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic                  drop_q, drop_d;
    logic [PADDR_SIZE-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0]  data_q, data_d;
    logic                  inv_pending_q, inv_pending_d;
    logic [PADDR_SIZE-1:0] inv_paddr_q, inv_paddr_d;
    logic                  req_ready_s;
    logic                  inv_out_s;

    // Acceptance is also gated by rstn_i so the icache sees no ready while in reset.
    assign req_ready_s = (state_q == S_IDLE) && !flush_i && rstn_i;
    // The invalidation yields to the refill response so the two never share a cycle.
    assign inv_out_s   = inv_pending_q && (state_q != S_RESP);

    // Refill FSM next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (ifill_req_valid_i && req_ready_s) begin
                    addr_d  = ifill_req_paddr_i & LINE_MASK;
                    beat_d  = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (mem_req_ready_i) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DATA: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (mem_resp_valid_i) begin
                    data_d[int'(beat_q) * BEAT_BITS +: BEAT_BITS] = mem_resp_data_i;
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                drop_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                drop_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // One-entry invalidation buffer; refilled only after it has drained.
    always_comb begin
        inv_pending_d = inv_pending_q;
        inv_paddr_d   = inv_paddr_q;
        if (inv_out_s) begin
            inv_pending_d = 1'b0;
        end else if (inv_valid_i && !inv_pending_q) begin
            inv_pending_d = 1'b1;
            inv_paddr_d   = inv_paddr_i;
        end else begin
            inv_pending_d = inv_pending_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            drop_q        <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            inv_pending_q <= 1'b0;
            inv_paddr_q   <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            drop_q        <= drop_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            inv_pending_q <= inv_pending_d;
            inv_paddr_q   <= inv_paddr_d;
        end
    end

    // A flush landing in the response cycle itself also discards that response.
    assign ifill_resp_valid_o     = (state_q == S_RESP) && !drop_q && !flush_i;
    assign ifill_resp_ack_o       = ifill_resp_valid_o;
    assign ifill_resp_data_o      = data_q;
    assign ifill_req_ready_o      = req_ready_s;
    assign mem_req_valid_o        = (state_q == S_REQ);
    assign mem_req_addr_o         = addr_q;
    assign ifill_resp_inv_valid_o = inv_out_s;
    assign ifill_resp_inv_paddr_o = inv_paddr_q;
    assign inv_ready_o            = !inv_pending_q;

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge: refill latency, backpressure, flush,
// invalidation ordering and mid-transaction reset.
module tb_icache_refill_bridge;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic [39:0]  req_paddr = 40'd0;
    logic         req_ready;
    logic         resp_valid;
    logic         resp_ack;
    logic [127:0] resp_data;
    logic         rinv_valid;
    logic [39:0]  rinv_paddr;
    logic         mreq_valid;
    logic         mreq_ready = 1'b0;
    logic [39:0]  mreq_addr;
    logic         mresp_valid = 1'b0;
    logic [63:0]  mresp_data = 64'd0;
    logic         inv_valid = 1'b0;
    logic [39:0]  inv_paddr = 40'd0;
    logic         inv_ready;

    int checks = 0;
    int errors = 0;

    icache_refill_bridge dut (
        .clk_i                  (clk),
        .rstn_i                 (rstn),
        .flush_i                (flush),
        .ifill_req_valid_i      (req_valid),
        .ifill_req_paddr_i      (req_paddr),
        .ifill_req_ready_o      (req_ready),
        .ifill_resp_valid_o     (resp_valid),
        .ifill_resp_ack_o       (resp_ack),
        .ifill_resp_data_o      (resp_data),
        .ifill_resp_inv_valid_o (rinv_valid),
        .ifill_resp_inv_paddr_o (rinv_paddr),
        .mem_req_valid_o        (mreq_valid),
        .mem_req_ready_i        (mreq_ready),
        .mem_req_addr_o         (mreq_addr),
        .mem_resp_valid_i       (mresp_valid),
        .mem_resp_data_i        (mresp_data),
        .inv_valid_i            (inv_valid),
        .inv_paddr_i            (inv_paddr),
        .inv_ready_o            (inv_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full refill with immediate memory ready; call in an IDLE cycle.
    task automatic do_refill(input string tag, input logic [39:0] pa, input logic [39:0] exp_addr,
                             input logic [63:0] b0, input logic [63:0] b1, input logic [127:0] exp_line);
        req_valid = 1'b1; req_paddr = pa; settle();
        chk({tag, ".req_ready"}, 128'(req_ready), 128'd1);
        tick(); req_valid = 1'b0; mreq_ready = 1'b1; settle();
        chk({tag, ".mreq_valid"}, 128'(mreq_valid), 128'd1);
        chk({tag, ".mreq_addr"}, 128'(mreq_addr), 128'(exp_addr));
        tick(); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = b0; settle();
        chk({tag, ".no_early_resp"}, 128'(resp_valid), 128'd0);
        tick(); mresp_data = b1;
        tick(); mresp_valid = 1'b0; settle();
        chk({tag, ".resp_valid"}, 128'(resp_valid), 128'd1);
        chk({tag, ".resp_ack"}, 128'(resp_ack), 128'd1);
        chk({tag, ".resp_data"}, resp_data, exp_line);
        tick(); settle();
        chk({tag, ".resp_one_cycle"}, 128'(resp_valid), 128'd0);
        chk({tag, ".back_idle"}, 128'(req_ready), 128'd1);
        chk({tag, ".data_held"}, resp_data, exp_line);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst.req_ready", 128'(req_ready), 128'd0);
        chk("rst.mreq_valid", 128'(mreq_valid), 128'd0);
        chk("rst.resp_valid", 128'(resp_valid), 128'd0);
        chk("rst.inv_valid", 128'(rinv_valid), 128'd0);
        chk("rst.data", resp_data, 128'd0);
        chk("rst.addr", 128'(mreq_addr), 128'd0);
        rstn = 1'b1;
        tick(); settle();
        chk("post_rst.req_ready", 128'(req_ready), 128'd1);

        // Basic refill
        do_refill("basic", 40'h00_8000_1234, 40'h00_8000_1230,
                  64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
                  128'hBBBB_0000_0000_0002_AAAA_0000_0000_0001);

        // Memory backpressure: five stalled REQ cycles
        req_valid = 1'b1; req_paddr = 40'h00_0000_0ABC; settle();
        chk("bp.req_ready", 128'(req_ready), 128'd1);
        tick(); req_valid = 1'b0; mreq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp.mreq_valid_stall", 128'(mreq_valid), 128'd1);
            chk("bp.mreq_addr_stall", 128'(mreq_addr), 128'h0AB0);
            chk("bp.not_ready", 128'(req_ready), 128'd0);
            tick();
        end
        mreq_ready = 1'b1; settle();
        chk("bp.mreq_valid_hs", 128'(mreq_valid), 128'd1);
        tick(); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h1111_2222_3333_4444;
        tick(); mresp_data = 64'h5555_6666_7777_8888;
        tick(); mresp_valid = 1'b0; settle();
        chk("bp.resp_valid", 128'(resp_valid), 128'd1);
        chk("bp.resp_data", resp_data, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
        tick(); settle();
        chk("bp.resp_one_cycle", 128'(resp_valid), 128'd0);

        // Flush during DATA after beat 0
        req_valid = 1'b1; req_paddr = 40'h00_0000_0100; settle();
        tick(); req_valid = 1'b0; mreq_ready = 1'b1;
        tick(); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'hCCCC_0000_0000_0003;
        tick(); flush = 1'b1; mresp_data = 64'hDDDD_0000_0000_0004; settle();
        chk("flush.no_resp_data", 128'(resp_valid), 128'd0);
        tick(); flush = 1'b0; mresp_valid = 1'b0; settle();
        chk("flush.resp_dropped", 128'(resp_valid), 128'd0);
        chk("flush.ack_dropped", 128'(resp_ack), 128'd0);
        chk("flush.not_idle_yet", 128'(req_ready), 128'd0);
        tick(); settle();
        chk("flush.idle", 128'(req_ready), 128'd1);
        // Flush in IDLE blocks acceptance for that cycle only
        flush = 1'b1; req_valid = 1'b1; req_paddr = 40'h00_0000_2468; settle();
        chk("idle_flush.blocked", 128'(req_ready), 128'd0);
        tick(); flush = 1'b0; req_valid = 1'b0; settle();
        chk("idle_flush.no_req", 128'(mreq_valid), 128'd0);
        do_refill("after_flush", 40'h00_0000_2468, 40'h00_0000_2460,
                  64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);

        // Invalidation colliding with RESP, second inv stalled until drain
        req_valid = 1'b1; req_paddr = 40'h00_0000_3000; settle();
        tick(); req_valid = 1'b0; mreq_ready = 1'b1;
        tick(); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h0000_0000_0000_00A1;
        tick(); mresp_data = 64'h0000_0000_0000_00B2;
        inv_valid = 1'b1; inv_paddr = 40'h00_0000_4000; settle();
        chk("inv.ready_first", 128'(inv_ready), 128'd1);
        tick(); mresp_valid = 1'b0; inv_paddr = 40'h00_0000_8000; settle();
        chk("inv.resp_valid", 128'(resp_valid), 128'd1);
        chk("inv.deferred", 128'(rinv_valid), 128'd0);
        chk("inv.stall_second", 128'(inv_ready), 128'd0);
        tick(); settle();
        chk("inv.out_valid", 128'(rinv_valid), 128'd1);
        chk("inv.out_paddr", 128'(rinv_paddr), 128'h4000);
        chk("inv.no_resp", 128'(resp_valid), 128'd0);
        chk("inv.still_stalled", 128'(inv_ready), 128'd0);
        tick(); settle();
        chk("inv.drained", 128'(rinv_valid), 128'd0);
        chk("inv.ready_again", 128'(inv_ready), 128'd1);
        tick(); inv_valid = 1'b0; settle();
        chk("inv.second_valid", 128'(rinv_valid), 128'd1);
        chk("inv.second_paddr", 128'(rinv_paddr), 128'h8000);
        tick(); settle();
        chk("inv.second_done", 128'(rinv_valid), 128'd0);

        // Reset between beats in DATA
        req_valid = 1'b1; req_paddr = 40'h00_0000_5000; settle();
        tick(); req_valid = 1'b0; mreq_ready = 1'b1;
        tick(); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'hEEEE_0000_0000_0005;
        tick(); mresp_valid = 1'b0; rstn = 1'b0; settle();
        chk("rstmid.data_zero", resp_data, 128'd0);
        chk("rstmid.req_ready", 128'(req_ready), 128'd0);
        chk("rstmid.mreq_valid", 128'(mreq_valid), 128'd0);
        chk("rstmid.addr_zero", 128'(mreq_addr), 128'd0);
        tick(); rstn = 1'b1;
        tick(); mresp_valid = 1'b1; mresp_data = 64'hFFFF_0000_0000_0006; settle();
        chk("rstmid.idle", 128'(req_ready), 128'd1);
        tick(); mresp_valid = 1'b0; settle();
        chk("rstmid.stray_ignored", resp_data, 128'd0);
        chk("rstmid.no_resp", 128'(resp_valid), 128'd0);
        do_refill("after_rst", 40'h00_0000_6008, 40'h00_0000_6000,
                  64'h1234_0000_0000_0007, 64'h5678_0000_0000_0008,
                  128'h5678_0000_0000_0008_1234_0000_0000_0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
